hub75e_bcm_scheduler: RTL and testbench

- Scan controller for a HUB75E LED panel with an upper and a lower half.
- Each frame-buffer word holds one 15-bit pixel per half: R[14:10], B[9:5], G[4:0].
- For every row and every bit-plane, the block reads one row of words from the pixel ROM/RAM and shifts out that plane's bits. It then latches the row and drives OE for a binary-weighted time (binary code modulation), scaled by a global brightness value.
- It sits between the pixel memory and the panel pins. It replaces the threshold-compare PWM with BCM timing at a constant refresh rate.

---
 rtl/hub75e_bcm_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_hub75e_bcm_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75e_bcm_scheduler.sv
// HUB75E scan controller: for each row and bit-plane it fetches a row of pixels,
// shifts that plane out, latches it and holds OE for a binary-weighted, dimmed window.
//
// state   | meaning
// IDLE    | waiting for enable at a frame boundary
// SHIFT   | fetch one row of words and clock the current plane's bits out
// LATCH   | pulse ST and update the row select
// DISPLAY | window of OE_BASE<<plane cycles, OE low for the brightness-scaled part
// BLANK   | OE off, then advance plane/row or finish the frame
module hub75e_bcm_scheduler #(
    parameter int ROW_BITS  = 5,
    parameter int COL_BITS  = 6,
    parameter int PWM_BITS  = 5,
    parameter int OE_BASE   = 8,
    parameter int BLANK_CYC = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         enable,
    input  logic [7:0]                   brightness,
    output logic [ROW_BITS+COL_BITS-1:0] ram_addr,
    output logic                         ram_re,
    input  logic [14:0]                  ram_rdata1,
    input  logic [14:0]                  ram_rdata2,
    output logic                         hub_R1,
    output logic                         hub_G1,
    output logic                         hub_B1,
    output logic                         hub_R2,
    output logic                         hub_G2,
    output logic                         hub_B2,
    output logic                         hub_ck,
    output logic                         hub_st,
    output logic                         hub_oe,
    output logic [ROW_BITS-1:0]          rows,
    output logic                         frame_start,
    output logic                         frame_done
);

    localparam int COL_CNT    = 1 << COL_BITS;
    localparam int SHIFT_LAST = 2 * COL_CNT + 1;
    localparam int SHIFT_W    = $clog2(SHIFT_LAST + 1);
    localparam int DISP_MAX   = OE_BASE << (PWM_BITS - 1);
    localparam int DISP_W     = $clog2(DISP_MAX + 1);
    localparam int PROD_W     = DISP_W + 9;
    localparam int BLANK_W    = $clog2(BLANK_CYC + 1);
    localparam int TMR_W      = (DISP_W > BLANK_W) ? DISP_W : BLANK_W;
    localparam int PLANE_W    = $clog2(PWM_BITS);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        LATCH,
        DISPLAY,
        BLANK
    } state_t;

    state_t                        state_q, state_d;
    logic [ROW_BITS-1:0]           row_q, row_d;
    logic [PLANE_W-1:0]            plane_q, plane_d;
    logic [SHIFT_W-1:0]            sidx_q, sidx_d;
    logic [TMR_W-1:0]              tmr_q, tmr_d;
    logic [DISP_W-1:0]             on_cnt_q, on_cnt_d;

    logic [ROW_BITS+COL_BITS-1:0]  ram_addr_q, ram_addr_d;
    logic                          ram_re_q, ram_re_d;
    logic [5:0]                    hub_dat_q, hub_dat_d;
    logic                          hub_ck_q, hub_ck_d;
    logic                          hub_st_q, hub_st_d;
    logic                          hub_oe_q, hub_oe_d;
    logic [ROW_BITS-1:0]           rows_q, rows_d;
    logic                          frame_start_q, frame_start_d;
    logic                          frame_done_q, frame_done_d;

    logic [DISP_W-1:0]             disp_len;
    logic [8:0]                    bright_p1;
    logic [PROD_W-1:0]             on_prod;
    logic [DISP_W-1:0]             on_len;
    logic [4:0]                    pix_r1, pix_g1, pix_b1, pix_r2, pix_g2, pix_b2;
    logic                          capture;
    logic                          last_plane, last_row;

    // Full-width product so brightness+1 = 256 reproduces the whole window.
    assign disp_len  = DISP_W'(OE_BASE) << plane_q;
    assign bright_p1 = {1'b0, brightness} + 9'd1;
    assign on_prod   = PROD_W'(disp_len) * PROD_W'(bright_p1);
    assign on_len    = DISP_W'(on_prod >> 8);

    assign pix_r1 = ram_rdata1[14:10];
    assign pix_b1 = ram_rdata1[9:5];
    assign pix_g1 = ram_rdata1[4:0];
    assign pix_r2 = ram_rdata2[14:10];
    assign pix_b2 = ram_rdata2[9:5];
    assign pix_g2 = ram_rdata2[4:0];

    assign last_plane = (plane_q == PLANE_W'(PWM_BITS - 1));
    assign last_row   = (row_q == {ROW_BITS{1'b1}});

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        plane_d  = plane_q;
        sidx_d   = sidx_q;
        tmr_d    = tmr_q;
        on_cnt_d = on_cnt_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = SHIFT;
                    row_d   = '0;
                    plane_d = '0;
                    sidx_d  = '0;
                end
            end
            SHIFT: begin
                if (sidx_q == SHIFT_W'(SHIFT_LAST)) state_d = LATCH;
                else                                sidx_d  = sidx_q + SHIFT_W'(1);
            end
            LATCH: begin
                state_d  = DISPLAY;
                tmr_d    = TMR_W'(disp_len) - TMR_W'(1);
                on_cnt_d = on_len;
            end
            DISPLAY: begin
                if (on_cnt_q != '0) on_cnt_d = on_cnt_q - DISP_W'(1);
                if (tmr_q == '0) begin
                    state_d = BLANK;
                    tmr_d   = TMR_W'(BLANK_CYC - 1);
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            BLANK: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end else begin
                    state_d = SHIFT;
                    sidx_d  = '0;
                    if (!last_plane) begin
                        plane_d = plane_q + PLANE_W'(1);
                    end else begin
                        plane_d = '0;
                        row_d   = row_q + ROW_BITS'(1);
                        if (last_row && !enable) state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they line up with the state.
    always_comb begin
        capture       = (state_q == SHIFT) && sidx_q[0] && (sidx_q < SHIFT_W'(2 * COL_CNT));
        ram_re_d      = (state_d == SHIFT) && !sidx_d[0] && (sidx_d < SHIFT_W'(2 * COL_CNT));
        ram_addr_d    = ram_re_d ? {row_d, sidx_d[COL_BITS:1]} : ram_addr_q;
        hub_ck_d      = (state_d == SHIFT) && sidx_d[0] && (sidx_d >= SHIFT_W'(3));
        hub_dat_d     = capture ? {pix_r1[plane_q], pix_g1[plane_q], pix_b1[plane_q],
                                   pix_r2[plane_q], pix_g2[plane_q], pix_b2[plane_q]}
                                : hub_dat_q;
        hub_st_d      = (state_d == LATCH);
        rows_d        = (state_q == LATCH) ? row_q : rows_q;
        hub_oe_d      = !((state_d == DISPLAY) && (on_cnt_d != '0));
        frame_start_d = (state_d == SHIFT) && (sidx_d == '0) && (row_d == '0) && (plane_d == '0);
        frame_done_d  = (state_d == BLANK) && (tmr_d == '0) && last_plane && last_row;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            row_q         <= '0;
            plane_q       <= '0;
            sidx_q        <= '0;
            tmr_q         <= '0;
            on_cnt_q      <= '0;
            ram_addr_q    <= '0;
            ram_re_q      <= 1'b0;
            hub_dat_q     <= '0;
            hub_ck_q      <= 1'b0;
            hub_st_q      <= 1'b0;
            hub_oe_q      <= 1'b1;
            rows_q        <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            plane_q       <= plane_d;
            sidx_q        <= sidx_d;
            tmr_q         <= tmr_d;
            on_cnt_q      <= on_cnt_d;
            ram_addr_q    <= ram_addr_d;
            ram_re_q      <= ram_re_d;
            hub_dat_q     <= hub_dat_d;
            hub_ck_q      <= hub_ck_d;
            hub_st_q      <= hub_st_d;
            hub_oe_q      <= hub_oe_d;
            rows_q        <= rows_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign ram_addr    = ram_addr_q;
    assign ram_re      = ram_re_q;
    assign hub_R1      = hub_dat_q[5];
    assign hub_G1      = hub_dat_q[4];
    assign hub_B1      = hub_dat_q[3];
    assign hub_R2      = hub_dat_q[2];
    assign hub_G2      = hub_dat_q[1];
    assign hub_B2      = hub_dat_q[0];
    assign hub_ck      = hub_ck_q;
    assign hub_st      = hub_st_q;
    assign hub_oe      = hub_oe_q;
    assign rows        = rows_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_hub75e_bcm_scheduler.sv
// Bench for hub75e_bcm_scheduler: a per-cycle scan-schedule model (row, plane, offset
// within the plane) predicts every output; literal checks pin plane timing and OE runs.
module tb_hub75e_bcm_scheduler;

    localparam int RB = 2, CB = 2, PB = 5, OB = 4, BC = 2;
    localparam int C = 1 << CB, NR = 1 << RB, SH = 2 * C + 2;
    localparam int FRAME = 756;   // 4 rows * sum over planes of (13 + (4<<p))

    logic            clk, resetn, enable;
    logic [7:0]      brightness;
    logic [RB+CB-1:0] ram_addr;
    logic            ram_re;
    logic [14:0]     ram_rdata1, ram_rdata2;
    logic            hub_R1, hub_G1, hub_B1, hub_R2, hub_G2, hub_B2;
    logic            hub_ck, hub_st, hub_oe;
    logic [RB-1:0]   rows;
    logic            frame_start, frame_done;

    logic [14:0] mem1 [NR*C];
    logic [14:0] mem2 [NR*C];

    hub75e_bcm_scheduler #(.ROW_BITS(RB), .COL_BITS(CB), .PWM_BITS(PB), .OE_BASE(OB), .BLANK_CYC(BC)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .brightness(brightness),
        .ram_addr(ram_addr), .ram_re(ram_re), .ram_rdata1(ram_rdata1), .ram_rdata2(ram_rdata2),
        .hub_R1(hub_R1), .hub_G1(hub_G1), .hub_B1(hub_B1),
        .hub_R2(hub_R2), .hub_G2(hub_G2), .hub_B2(hub_B2),
        .hub_ck(hub_ck), .hub_st(hub_st), .hub_oe(hub_oe), .rows(rows),
        .frame_start(frame_start), .frame_done(frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (ram_re) begin
            ram_rdata1 <= mem1[ram_addr];
            ram_rdata2 <= mem2[ram_addr];
        end
    end

    int n_cmp, n_fail, cyc;
    int m_act, m_row, m_plane, m_t, m_onlen;
    logic [RB+CB-1:0] e_addr;
    logic [5:0]       e_data;
    logic [RB-1:0]    e_rows;
    int    rand_br;
    logic [7:0] br_fixed;

    int fs_cyc[$], fd_cyc[$], ck_pos[$], st_pos[$], re_pos[$], re_addr[$], runs[$], rows_chg[$];
    logic [5:0] ck_data[$];
    int oe_run, oe_low_cnt, re_cnt;
    logic [RB-1:0] rows_prev;

    function automatic int plen(input int p);
        return SH + 1 + (OB << p) + BC;
    endfunction

    function automatic logic [5:0] pix(input int idx, input int p);
        logic [14:0] a, b;
        a = mem1[idx];
        b = mem2[idx];
        return {a[10+p], a[p], a[5+p], b[10+p], b[p], b[5+p]};
    endfunction

    function automatic int qat(input int q[$], input int k);
        if (k < q.size()) return q[k];
        return -1;
    endfunction

    task automatic check1(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        fs_cyc.delete(); fd_cyc.delete(); ck_pos.delete(); st_pos.delete();
        re_pos.delete(); re_addr.delete(); runs.delete(); rows_chg.delete(); ck_data.delete();
        oe_run = 0; oe_low_cnt = 0; re_cnt = 0;
    endtask

    // Wait into the next cycle, derive what the schedule says it must show, compare.
    task automatic tick();
        int t, len;
        logic e_re, e_ck, e_st, e_oe, e_fs, e_fd;
        @(posedge clk);
        #1;
        cyc++;
        e_re = 0; e_ck = 0; e_st = 0; e_oe = 1; e_fs = 0; e_fd = 0;
        if (m_act != 0) begin
            t   = m_t;
            len = OB << m_plane;
            if (t < SH) begin
                e_fs = (t == 0 && m_row == 0 && m_plane == 0);
                if (t % 2 == 0 && t < 2 * C) begin
                    e_re   = 1;
                    e_addr = (RB+CB)'(m_row * C + t / 2);
                end
                e_ck = (t % 2 == 1 && t >= 3);
                if (t % 2 == 0 && t >= 2 && t <= 2 * C) e_data = pix(m_row * C + (t - 2) / 2, m_plane);
            end else if (t == SH) begin
                e_st = 1;
            end else if (t <= SH + len) begin
                if (t == SH + 1) e_rows = RB'(m_row);
                e_oe = !((t - SH - 1) < m_onlen);
            end else begin
                e_fd = (t == plen(m_plane) - 1 && m_plane == PB - 1 && m_row == NR - 1);
            end
        end
        check1("ram_addr", int'(ram_addr), int'(e_addr));
        check1("ram_re", int'(ram_re), int'(e_re));
        check1("hub_data", int'({hub_R1, hub_G1, hub_B1, hub_R2, hub_G2, hub_B2}), int'(e_data));
        check1("hub_ck", int'(hub_ck), int'(e_ck));
        check1("hub_st", int'(hub_st), int'(e_st));
        check1("hub_oe", int'(hub_oe), int'(e_oe));
        check1("rows", int'(rows), int'(e_rows));
        check1("frame_start", int'(frame_start), int'(e_fs));
        check1("frame_done", int'(frame_done), int'(e_fd));

        if (frame_start) fs_cyc.push_back(cyc);
        if (frame_done) fd_cyc.push_back(cyc);
        if (hub_ck) begin
            ck_pos.push_back(cyc);
            ck_data.push_back({hub_R1, hub_G1, hub_B1, hub_R2, hub_G2, hub_B2});
        end
        if (hub_st) st_pos.push_back(cyc);
        if (ram_re) begin
            re_pos.push_back(cyc);
            re_addr.push_back(int'(ram_addr));
            re_cnt++;
        end
        if (rows != rows_prev) rows_chg.push_back(cyc);
        rows_prev = rows;
        if (!hub_oe) begin
            oe_run++;
            oe_low_cnt++;
        end else if (oe_run > 0) begin
            runs.push_back(oe_run);
            oe_run = 0;
        end
    endtask

    task automatic advance();
        if (!resetn) begin
            m_act = 0; e_addr = '0; e_data = '0; e_rows = '0;
            return;
        end
        if (m_act == 0) begin
            if (enable) begin
                m_act = 1; m_row = 0; m_plane = 0; m_t = 0;
            end
            return;
        end
        if (m_t == SH) m_onlen = ((OB << m_plane) * (int'(brightness) + 1)) >> 8;
        if (m_t == plen(m_plane) - 1) begin
            m_t = 0;
            if (m_plane < PB - 1) begin
                m_plane++;
            end else begin
                m_plane = 0;
                if (m_row < NR - 1) begin
                    m_row++;
                end else begin
                    m_row = 0;
                    if (!enable) m_act = 0;
                end
            end
        end else begin
            m_t++;
        end
    endtask

    task automatic step(input logic en, input logic rn);
        logic rn_prev;
        tick();
        rn_prev = resetn;
        enable  = en;
        resetn  = rn;
        if (m_act == 0 || m_t == 0)
            brightness = (rand_br != 0) ? 8'($urandom_range(0, 255)) : br_fixed;
        if (rn_prev && !rn) begin
            #1;
            check1("async_oe", int'(hub_oe), 1);
            check1("async_rows", int'(rows), 0);
            check1("async_re", int'(ram_re), 0);
        end
        advance();
    endtask

    task automatic run_one_frame(input int tail);
        step(1'b1, 1'b1);
        repeat (FRAME + tail) step(1'b0, 1'b1);
    endtask

    initial begin
        int fs0, n, found, rel;
        logic en;
        n_cmp = 0; n_fail = 0; cyc = 0;
        m_act = 0; m_row = 0; m_plane = 0; m_t = 0; m_onlen = 0;
        e_addr = '0; e_data = '0; e_rows = '0; rows_prev = '0;
        rand_br = 0; br_fixed = 8'd255;
        resetn = 1'b0; enable = 1'b0; brightness = 8'd255;
        for (int i = 0; i < NR * C; i++) begin
            mem1[i] = 15'h7C00;
            mem2[i] = 15'h001F;
        end
        clear_stats();

        // Held in reset
        repeat (20) step(1'b0, 1'b0);
        check1("reset_re_count", re_cnt, 0);
        check1("reset_oe", int'(hub_oe), 1);
        repeat (5) step(1'b0, 1'b1);

        // One-cycle enable, full brightness, fixed pixels
        clear_stats();
        run_one_frame(44);
        fs0 = qat(fs_cyc, 0);
        check1("frame_start_count", fs_cyc.size(), 1);
        check1("frame_done_count", fd_cyc.size(), 1);
        check1("frame_len", qat(fd_cyc, 0) - fs0 + 1, FRAME);
        for (int k = 0; k < 4; k++) begin
            check1("re_pos", qat(re_pos, k) - fs0, 2 * k);
            check1("re_addr", qat(re_addr, k), k);
            check1("ck_pos", qat(ck_pos, k) - fs0, 3 + 2 * k);
            check1("ck_data", (k < ck_data.size()) ? int'(ck_data[k]) : -1, 6'b100010);
        end
        n = 0;
        foreach (ck_pos[i]) if (ck_pos[i] - fs0 <= SH) n++;
        check1("ck_plane0_count", n, 4);
        check1("st_pos", qat(st_pos, 0) - fs0, 10);
        check1("row1_latch", qat(st_pos, 5) - fs0, 199);
        check1("rows_0_to_1", qat(rows_chg, 0) - fs0, 200);
        for (int p = 0; p < PB; p++) check1("oe_run_b255", qat(runs, p), 4 << p);

        // Half brightness
        br_fixed = 8'd127;
        clear_stats();
        run_one_frame(4);
        for (int p = 0; p < PB; p++) check1("oe_run_b127", qat(runs, p), 2 << p);

        // Zero brightness
        br_fixed = 8'd0;
        clear_stats();
        run_one_frame(4);
        check1("oe_low_b0", oe_low_cnt, 0);
        check1("frame_start_b0", fs_cyc.size(), 1);

        // Random pixels, random brightness per plane, enable wiggling mid-frame
        for (int i = 0; i < NR * C; i++) begin
            mem1[i] = 15'($urandom);
            mem2[i] = 15'($urandom);
        end
        rand_br = 1;
        clear_stats();
        step(1'b1, 1'b1);
        repeat (3 * FRAME + 10) begin
            if (m_act != 0 && !(m_row == NR - 1 && m_plane == PB - 1 && m_t == plen(PB - 1) - 1))
                en = 1'($urandom_range(0, 1));
            else
                en = 1'b1;
            step(en, 1'b1);
        end
        check1("fs_interval_1", qat(fs_cyc, 1) - qat(fs_cyc, 0), FRAME);
        check1("fs_interval_2", qat(fs_cyc, 2) - qat(fs_cyc, 1), FRAME);
        repeat (FRAME + 10) step(1'b0, 1'b1);

        // Reset during a plane-2 display window of row 1
        rand_br = 0; br_fixed = 8'd255;
        found = 0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            if (m_act != 0 && m_row == 1 && m_plane == 2 && m_t == SH + 5) found = 1;
            else step(1'b1, 1'b1);
        end
        check1("reach_plane2_display", found, 1);
        step(1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0);
        clear_stats();
        step(1'b1, 1'b1);
        rel = cyc;
        repeat (30) step(1'b1, 1'b1);
        check1("restart_frame_start", qat(fs_cyc, 0) - rel, 1);
        check1("restart_addr0", qat(re_addr, 0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
